// File: rtl/pll_reset_seq.sv
// Reset and lock sequencer for the NES clock PLL: pulses the PLL reset, qualifies
// the asynchronous lock flag and holds the core in reset until the clock is stable.
module pll_reset_seq #(
    parameter int PLL_RST_CYCLES     = 16,
    parameter int LOCK_TIMEOUT       = 270000,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int RELEASE_DELAY      = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic       sys_reset,
    output logic       ready,
    output logic [7:0] relock_count,
    output logic [7:0] timeout_count,
    // 0=PLL_RST 1=WAIT_LOCK 2=STABLE 3=HOLD 4=RUN
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_HOLD      = 3'd3,
        ST_RUN       = 3'd4
    } state_t;

    localparam logic [23:0] PLL_RST_LAST = 24'(PLL_RST_CYCLES - 1);
    localparam logic [23:0] TIMEOUT_LAST = 24'(LOCK_TIMEOUT - 1);
    localparam logic [23:0] STABLE_LAST  = 24'(LOCK_STABLE_CYCLES - 1);
    localparam logic [23:0] RELEASE_LAST = 24'(RELEASE_DELAY - 1);

    state_t      state;
    state_t      state_next;
    logic [23:0] cnt;
    logic [23:0] cnt_next;
    logic        lock_meta;
    logic        lock_s;
    logic        timeout_inc;
    logic        relock_inc;

    // pll_lock comes from the PLL with no timing relation to clk.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_lock;
            lock_s    <= lock_meta;
        end
    end

    always_comb begin
        state_next  = state;
        timeout_inc = 1'b0;
        relock_inc  = 1'b0;
        case (state)
            ST_PLL_RST: begin
                if (cnt == PLL_RST_LAST) state_next = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    state_next = ST_STABLE;
                end else if (cnt == TIMEOUT_LAST) begin
                    state_next  = ST_PLL_RST;
                    timeout_inc = 1'b1;
                end
            end
            ST_STABLE: begin
                if (!lock_s) state_next = ST_WAIT_LOCK;
                else if (cnt == STABLE_LAST) state_next = ST_HOLD;
            end
            ST_HOLD: begin
                if (!lock_s) state_next = ST_WAIT_LOCK;
                else if (cnt == RELEASE_LAST) state_next = ST_RUN;
            end
            ST_RUN: begin
                if (!lock_s) begin
                    state_next = ST_PLL_RST;
                    relock_inc = 1'b1;
                end
            end
            default: state_next = ST_PLL_RST;
        endcase
    end

    // The counter restarts on every state entry and idles in RUN, where nothing times out.
    always_comb begin
        cnt_next = cnt + 24'd1;
        if (state_next != state) cnt_next = 24'd0;
        else if (state == ST_RUN) cnt_next = cnt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_PLL_RST;
            cnt           <= 24'd0;
            pll_reset     <= 1'b1;
            sys_reset     <= 1'b1;
            ready         <= 1'b0;
            relock_count  <= 8'd0;
            timeout_count <= 8'd0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            pll_reset <= (state_next == ST_PLL_RST);
            sys_reset <= (state_next != ST_RUN);
            ready     <= (state_next == ST_RUN);
            if (relock_inc && relock_count != 8'hFF) relock_count <= relock_count + 8'd1;
            if (timeout_inc && timeout_count != 8'hFF) timeout_count <= timeout_count + 8'd1;
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Bench for pll_reset_seq with short timings; expected outputs are queued per
// clk edge number and compared when that edge has been reached.
module tb_pll_reset_seq;

    localparam logic [2:0] S_PLL_RST = 3'd0;
    localparam logic [2:0] S_WAIT    = 3'd1;
    localparam logic [2:0] S_STABLE  = 3'd2;
    localparam logic [2:0] S_HOLD    = 3'd3;
    localparam logic [2:0] S_RUN     = 3'd4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_lock = 1'b0;
    logic       pll_reset;
    logic       sys_reset;
    logic       ready;
    logic [7:0] relock_count;
    logic [7:0] timeout_count;
    logic [2:0] state_dbg;

    int n_checks = 0;
    int n_fail   = 0;
    int edge_n;

    logic [21:0] exp_q[$];
    int          edge_q[$];
    string       tag_q[$];

    pll_reset_seq #(
        .PLL_RST_CYCLES    (4),
        .LOCK_TIMEOUT      (32),
        .LOCK_STABLE_CYCLES(8),
        .RELEASE_DELAY     (4)
    ) dut (
        .clk          (clk),
        .reset        (rst),
        .pll_lock     (pll_lock),
        .pll_reset    (pll_reset),
        .sys_reset    (sys_reset),
        .ready        (ready),
        .relock_count (relock_count),
        .timeout_count(timeout_count),
        .state_dbg    (state_dbg)
    );

    // ---------------- clock / reset / edge numbering ----------------
    always #5 clk = ~clk;

    // Edge 1 is the first rising edge after reset deasserts.
    always @(posedge clk or posedge rst) begin
        if (rst) edge_n <= 0;
        else     edge_n <= edge_n + 1;
    end

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    task automatic expect_at(input int e, input string tag, input logic [2:0] st,
                             input logic pr, input logic sr, input logic rdy,
                             input logic [7:0] rl, input logic [7:0] tm);
        edge_q.push_back(e);
        tag_q.push_back(tag);
        exp_q.push_back({st, pr, sr, rdy, rl, tm});
    endtask

    task automatic sb_drain();
        int          e;
        logic [21:0] v;
        string       t;
        while (edge_q.size() > 0 && edge_q[0] <= edge_n) begin
            e = edge_q.pop_front();
            v = exp_q.pop_front();
            t = tag_q.pop_front();
            if (e != edge_n) begin
                check_eq({t, ".edge"}, edge_n, e);
            end else begin
                check_eq({t, ".state"},     32'(state_dbg),     32'(v[21:19]));
                check_eq({t, ".pll_reset"}, 32'(pll_reset),     32'(v[18]));
                check_eq({t, ".sys_reset"}, 32'(sys_reset),     32'(v[17]));
                check_eq({t, ".ready"},     32'(ready),         32'(v[16]));
                check_eq({t, ".relock"},    32'(relock_count),  32'(v[15:8]));
                check_eq({t, ".timeout"},   32'(timeout_count), 32'(v[7:0]));
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
        sb_drain();
    endtask

    task automatic wait_edge(input int n);
        int budget = 0;
        while (edge_n < n && budget < 20000) begin
            tick();
            budget++;
        end
        if (edge_n < n) check_eq("wait_edge", edge_n, n);
    endtask

    // Called just after a falling edge; reset pulse lies entirely between rising edges.
    task automatic apply_reset(input string tag);
        rst = 1'b1;
        #1;
        check_eq({tag, ".pll_reset"}, 32'(pll_reset),     1);
        check_eq({tag, ".sys_reset"}, 32'(sys_reset),     1);
        check_eq({tag, ".ready"},     32'(ready),         0);
        check_eq({tag, ".relock"},    32'(relock_count),  0);
        check_eq({tag, ".timeout"},   32'(timeout_count), 0);
        check_eq({tag, ".state"},     32'(state_dbg),     32'(S_PLL_RST));
        #1;
        rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic fell;
        int   budget;

        tick();
        tick();
        apply_reset("por");

        // Lock tied low: repeated timeouts, counter saturates, core never released.
        expect_at(1,     "low.e1",    S_PLL_RST, 1, 1, 0, 0, 0);
        expect_at(3,     "low.e3",    S_PLL_RST, 1, 1, 0, 0, 0);
        expect_at(4,     "low.e4",    S_WAIT,    0, 1, 0, 0, 0);
        expect_at(35,    "low.e35",   S_WAIT,    0, 1, 0, 0, 0);
        expect_at(36,    "low.e36",   S_PLL_RST, 1, 1, 0, 0, 1);
        expect_at(40,    "low.e40",   S_WAIT,    0, 1, 0, 0, 1);
        expect_at(72,    "low.e72",   S_PLL_RST, 1, 1, 0, 0, 2);
        expect_at(36*254, "low.t254", S_PLL_RST, 1, 1, 0, 0, 254);
        expect_at(36*255, "low.t255", S_PLL_RST, 1, 1, 0, 0, 255);
        expect_at(36*256, "low.t256", S_PLL_RST, 1, 1, 0, 0, 255);
        expect_at(36*300, "low.t300", S_PLL_RST, 1, 1, 0, 0, 255);
        expect_at(36*300+4, "low.end", S_WAIT,   0, 1, 0, 0, 255);
        fell   = 1'b0;
        budget = 0;
        while (edge_n < 36*300+4 && budget < 12000) begin
            tick();
            budget++;
            if (!sys_reset) fell = 1'b1;
        end
        check_eq("low.sys_never_fell", 32'(fell), 0);
        check_eq("low.reached_end", edge_n, 36*300+4);

        apply_reset("rst2");

        // Clean lock sampled first at edge 10: release at 24.
        expect_at(11, "lock.e11", S_WAIT,   0, 1, 0, 0, 0);
        expect_at(12, "lock.e12", S_STABLE, 0, 1, 0, 0, 0);
        expect_at(19, "lock.e19", S_STABLE, 0, 1, 0, 0, 0);
        expect_at(20, "lock.e20", S_HOLD,   0, 1, 0, 0, 0);
        expect_at(23, "lock.e23", S_HOLD,   0, 1, 0, 0, 0);
        expect_at(24, "lock.e24", S_RUN,    0, 0, 1, 0, 0);
        // Lock loss sampled at 31, re-lock sampled at 41, uncaptured glitch after 60.
        expect_at(32, "loss.e32", S_RUN,     0, 0, 1, 0, 0);
        expect_at(33, "loss.e33", S_PLL_RST, 1, 1, 0, 1, 0);
        expect_at(36, "loss.e36", S_PLL_RST, 1, 1, 0, 1, 0);
        expect_at(37, "loss.e37", S_WAIT,    0, 1, 0, 1, 0);
        expect_at(42, "relk.e42", S_WAIT,    0, 1, 0, 1, 0);
        expect_at(43, "relk.e43", S_STABLE,  0, 1, 0, 1, 0);
        expect_at(54, "relk.e54", S_HOLD,    0, 1, 0, 1, 0);
        expect_at(55, "relk.e55", S_RUN,     0, 0, 1, 1, 0);
        expect_at(63, "glitch.e63", S_RUN,   0, 0, 1, 1, 0);
        // Second loss sampled at 65, re-lock sampled at 71.
        expect_at(66, "loss2.e66", S_RUN,     0, 0, 1, 1, 0);
        expect_at(67, "loss2.e67", S_PLL_RST, 1, 1, 0, 2, 0);
        expect_at(71, "loss2.e71", S_WAIT,    0, 1, 0, 2, 0);
        expect_at(72, "loss2.e72", S_WAIT,    0, 1, 0, 2, 0);
        expect_at(73, "loss2.e73", S_STABLE,  0, 1, 0, 2, 0);
        expect_at(81, "loss2.e81", S_HOLD,    0, 1, 0, 2, 0);

        wait_edge(9);
        pll_lock = 1'b1;
        wait_edge(30);
        pll_lock = 1'b0;
        wait_edge(40);
        pll_lock = 1'b1;
        wait_edge(60);
        pll_lock = 1'b0;
        #2;
        pll_lock = 1'b1;
        wait_edge(64);
        pll_lock = 1'b0;
        wait_edge(70);
        pll_lock = 1'b1;
        wait_edge(82);

        // Asynchronous reset in HOLD with lock still high.
        apply_reset("rst_hold");
        expect_at(1,  "rest.e1",  S_PLL_RST, 1, 1, 0, 0, 0);
        expect_at(3,  "rest.e3",  S_PLL_RST, 1, 1, 0, 0, 0);
        expect_at(4,  "rest.e4",  S_WAIT,    0, 1, 0, 0, 0);
        expect_at(5,  "rest.e5",  S_STABLE,  0, 1, 0, 0, 0);
        expect_at(16, "rest.e16", S_HOLD,    0, 1, 0, 0, 0);
        expect_at(17, "rest.e17", S_RUN,     0, 0, 1, 0, 0);
        wait_edge(20);

        // Glitch in STABLE: lock sampled low at 15..17, high again from 18.
        pll_lock = 1'b0;
        apply_reset("rst4");
        expect_at(16, "stgl.e16", S_STABLE, 0, 1, 0, 0, 0);
        expect_at(17, "stgl.e17", S_WAIT,   0, 1, 0, 0, 0);
        expect_at(19, "stgl.e19", S_WAIT,   0, 1, 0, 0, 0);
        expect_at(20, "stgl.e20", S_STABLE, 0, 1, 0, 0, 0);
        expect_at(31, "stgl.e31", S_HOLD,   0, 1, 0, 0, 0);
        expect_at(32, "stgl.e32", S_RUN,    0, 0, 1, 0, 0);
        wait_edge(9);
        pll_lock = 1'b1;
        wait_edge(14);
        pll_lock = 1'b0;
        wait_edge(17);
        pll_lock = 1'b1;
        wait_edge(34);

        check_eq("sb.leftover", edge_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
